// File: rtl/uart_prog_loader.sv
// UART program loader: receives an A5/LEN/data/SUM frame, writes the data into the
// CPU program RAM and holds the CPU in reset until a checksum-verified load completes.
module uart_prog_loader #(
  parameter int CLK_HZ      = 27_000_000,
  parameter int BAUD        = 115200,
  parameter int TIMEOUT_CYC = 2_700_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rx,
  output logic       wr_en,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       cpu_rst_n,
  output logic       loading,
  output logic       load_ok,
  output logic       load_err
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {S_IDLE, S_LEN, S_DATA, S_SUM} state_t;

  // ---------------- RX front end ----------------
  logic          rx_meta, rx_s, rx_prev;
  rx_state_t     rx_state, rx_next;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    rx_byte;
  logic          rx_valid, frame_err, bit_tick;

  // NOTE: every register below uses non-blocking assignments so all flops update
  // from the same pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  // NOTE: defaults first so every path assigns each signal and no latch is inferred.
  always_comb begin
    rx_next  = rx_state;
    bit_tick = (baud_cnt == ((rx_state == RX_START) ? HALF_LAST : BIT_LAST));
    case (rx_state)
      RX_IDLE:  if (rx_prev && !rx_s) rx_next = RX_START;
      RX_START: if (bit_tick) rx_next = rx_s ? RX_IDLE : RX_DATA;
      RX_DATA:  if (bit_tick && bit_idx == 3'd7) rx_next = RX_STOP;
      RX_STOP:  if (bit_tick) rx_next = RX_IDLE;
      default:  rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_state  <= RX_IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      rx_byte   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_state  <= rx_next;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      baud_cnt  <= (rx_state == RX_IDLE || bit_tick) ? '0 : baud_cnt + 1'b1;
      if (bit_tick) begin
        case (rx_state)
          RX_START: bit_idx <= '0;
          RX_DATA: begin
            rx_byte <= {rx_s, rx_byte[7:1]};  // LSB arrives first
            bit_idx <= bit_idx + 3'd1;
          end
          RX_STOP: begin
            rx_valid  <= rx_s;
            frame_err <= !rx_s;
          end
          default: ;
        endcase
      end
    end
  end

  // ---------------- Frame FSM ----------------
  state_t        state, state_next;
  logic [8:0]    remaining;
  logic [7:0]    sum;
  logic [TW-1:0] tmo_cnt;
  logic          timeout_hit, abort;

  assign timeout_hit = (tmo_cnt == TMO_LAST) && !rx_valid;

  always_comb begin
    state_next = state;
    abort      = 1'b0;
    case (state)
      S_IDLE: if (rx_valid && rx_byte == 8'hA5) state_next = S_LEN;
      S_LEN:  if (rx_valid) state_next = S_DATA;
      S_DATA: if (rx_valid && remaining == 9'd1) state_next = S_SUM;
      S_SUM:  if (rx_valid) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    if (state != S_IDLE && (frame_err || timeout_hit)) begin
      abort      = 1'b1;
      state_next = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      remaining <= '0;
      sum       <= '0;
      tmo_cnt   <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      cpu_rst_n <= 1'b1;
      loading   <= 1'b0;
      load_ok   <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      state   <= state_next;
      wr_en   <= 1'b0;
      tmo_cnt <= (state == S_IDLE || rx_valid || abort) ? '0 : tmo_cnt + 1'b1;
      // Address advances after the write it tagged, so the 256th byte lands at 255.
      if (wr_en) wr_addr <= wr_addr + 8'd1;
      if (rx_valid) begin
        case (state)
          S_IDLE: if (rx_byte == 8'hA5) begin
            loading   <= 1'b1;
            cpu_rst_n <= 1'b0;
            load_ok   <= 1'b0;
            load_err  <= 1'b0;
            wr_addr   <= '0;
            sum       <= '0;
          end
          S_LEN:  remaining <= {(rx_byte == 8'd0), rx_byte};
          S_DATA: begin
            wr_en     <= 1'b1;
            wr_data   <= rx_byte;
            sum       <= sum + rx_byte;
            remaining <= remaining - 9'd1;
          end
          S_SUM: begin
            loading <= 1'b0;
            if (rx_byte == sum) begin
              load_ok   <= 1'b1;
              cpu_rst_n <= 1'b1;
            end else begin
              load_err <= 1'b1;
            end
          end
          default: ;
        endcase
      end
      if (abort) begin
        load_err <= 1'b1;
        loading  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_prog_loader.sv
// Self-checking bench for uart_prog_loader: directed frames plus randomized frames,
// compared against a frame-level model (expected write list and checksum outcome).
module tb_uart_prog_loader;

  localparam int CLK_HZ = 1_000_000;
  localparam int BAUD   = 100_000;
  localparam int CPB    = CLK_HZ / BAUD;
  localparam int TMO    = 400;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       uart_rx = 1'b1;
  logic       wr_en, cpu_rst_n, loading, load_ok, load_err;
  logic [7:0] wr_addr, wr_data;

  int passed = 0;
  int total  = 0;
  int failed = 0;
  logic [15:0] exp_q[$];
  logic [7:0]  d[$];

  uart_prog_loader #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .uart_rx(uart_rx),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cpu_rst_n(cpu_rst_n), .loading(loading), .load_ok(load_ok), .load_err(load_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Status vector order: {loading, load_ok, load_err, cpu_rst_n}
  task automatic check_status(input string tag, input logic [3:0] exp);
    check(tag, {28'd0, loading, load_ok, load_err, cpu_rst_n}, {28'd0, exp});
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_stop = 1'b0);
    @(negedge clk);
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rx = !bad_stop;
    repeat (CPB) @(negedge clk);
    uart_rx = 1'b1;
    repeat (CPB + $urandom_range(0, 30)) @(negedge clk);
  endtask

  // Model: a complete frame writes data[i] at address i; the load passes iff
  // the SUM byte equals the modulo-256 sum of the data.
  task automatic send_frame(input string tag, input logic [7:0] data[$], input logic [7:0] sum_byte);
    int s = 0;
    for (int i = 0; i < data.size(); i++) begin
      exp_q.push_back({8'(i), data[i]});
      s += data[i];
    end
    send_byte(8'hA5);
    send_byte(8'(data.size()));
    check_status({tag, "_hdr"}, 4'b1000);
    for (int i = 0; i < data.size(); i++) send_byte(data[i]);
    send_byte(sum_byte);
    repeat (4) @(negedge clk);
    check({tag, "_writes_done"}, exp_q.size(), 0);
    if (8'(s) == sum_byte) check_status({tag, "_ok"}, 4'b0101);
    else                   check_status({tag, "_bad"}, 4'b0010);
  endtask

  // Write monitor: every write must match the next expected (addr, data).
  logic prev_wr = 1'b0, prev_ok = 1'b0, prev_cpu = 1'b1;
  always @(negedge clk) begin
    if (rst) begin
      if (wr_en) begin
        check("wr_single_cycle", {31'd0, prev_wr}, 0);
        check("cpu_held_on_write", {31'd0, cpu_rst_n}, 0);
        check("write_expected", {31'd0, exp_q.size() != 0}, 1);
        if (exp_q.size() != 0) check("write_addr_data", {16'd0, wr_addr, wr_data}, {16'd0, exp_q.pop_front()});
      end
      if (load_ok && !prev_ok) check("cpu_release_with_ok", {30'd0, prev_cpu, cpu_rst_n}, 2'b01);
    end
    prev_wr  = wr_en;
    prev_ok  = load_ok;
    prev_cpu = cpu_rst_n;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] good;
    int len;

    repeat (3) @(negedge clk);
    check("reset_outputs", {15'd0, wr_en, wr_addr, wr_data, loading, load_ok, load_err, cpu_rst_n},
          {15'd0, 1'b0, 8'h00, 8'h00, 4'b0001});
    rst = 1'b1;
    repeat (5) @(negedge clk);
    check_status("idle_after_reset", 4'b0001);

    d.delete(); d.push_back(8'h66); d.push_back(8'h80); d.push_back(8'h00);
    send_frame("t1", d, 8'hE6);

    d.delete(); d.push_back(8'h11); d.push_back(8'h22);
    send_frame("t2", d, 8'h00);

    send_byte(8'h5A);
    send_byte(8'h00);
    check_status("t3_junk_ignored", 4'b0010);
    d.delete(); d.push_back(8'h7F);
    send_frame("t3", d, 8'h7F);

    d.delete();
    for (int i = 0; i < 256; i++) d.push_back(8'(i));
    send_frame("t4_len256", d, 8'h80);

    exp_q.push_back({8'h00, 8'h01});
    exp_q.push_back({8'h01, 8'h02});
    send_byte(8'hA5); send_byte(8'h04); send_byte(8'h01); send_byte(8'h02);
    repeat (TMO + 100) @(negedge clk);
    check_status("t5_timeout", 4'b0010);
    check("t5_writes_done", exp_q.size(), 0);
    d.delete(); d.push_back(8'h55); d.push_back(8'hAA);
    send_frame("t5_restart", d, 8'hFF);

    exp_q.push_back({8'h00, 8'h10});
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h10);
    send_byte(8'h20, 1'b1);
    repeat (4) @(negedge clk);
    check_status("t6_framing", 4'b0010);
    check("t6_writes_done", exp_q.size(), 0);

    uart_rx = 1'b0;
    repeat (2) @(negedge clk);
    uart_rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    check_status("glitch_ignored", 4'b0010);

    for (int f = 0; f < 6; f++) begin
      len = $urandom_range(1, 12);
      d.delete();
      good = 8'h00;
      for (int i = 0; i < len; i++) begin
        d.push_back(8'($urandom));
        good = good + d[i];
      end
      if ($urandom_range(0, 2) == 0) good = good ^ (8'h01 << $urandom_range(0, 7));
      send_frame("rand", d, good);
    end

    exp_q.push_back({8'h00, 8'h33});
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h33);
    @(negedge clk);
    uart_rx = 1'b0;
    repeat (2 * CPB) @(negedge clk);
    rst = 1'b0;
    #1;
    check("t6_async_reset", {15'd0, wr_en, wr_addr, wr_data, loading, load_ok, load_err, cpu_rst_n},
          {15'd0, 1'b0, 8'h00, 8'h00, 4'b0001});
    check("t6_reset_writes_done", exp_q.size(), 0);
    uart_rx = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    d.delete(); d.push_back(8'hC3);
    send_frame("after_reset", d, 8'hC3);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
